// File: rtl/ndp_pkg.sv
// ============================================================================
// Module      : ndp_pkg
// Description : Shared types and width helpers for the NDP stream receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ndp_pkg;

    localparam int AXIS_W = 32;

    typedef enum logic [1:0] {
        S_ACT  = 2'd0,
        S_WGT  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    function automatic int a_bits(input int width, input int sys_h, input int arr_h);
        return sys_h * arr_h * width;
    endfunction

    function automatic int b_bits(input int width, input int sys_w, input int arr_w);
        return sys_w * arr_w * width;
    endfunction

    function automatic int words_of(input int bits);
        return bits / AXIS_W;
    endfunction

    // Counter width that stays legal for a single-entry range.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ndp_word_packer.sv
// ============================================================================
// Module      : ndp_word_packer
// Description : Writes 32-bit beats into a wide shadow register by word index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ndp_word_packer
    import ndp_pkg::*;
#(
    parameter  int WORDS = 2,
    localparam int CNT_W = cnt_w(WORDS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_wr_en,
    input  logic [AXIS_W-1:0]       i_wr_data,
    output logic [WORDS*AXIS_W-1:0] o_next,
    output logic [CNT_W-1:0]        o_count
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WORDS - 1);

    logic [WORDS*AXIS_W-1:0] r_shadow;
    logic [CNT_W-1:0]        r_count;
    logic [WORDS*AXIS_W-1:0] w_next;

    // Shadow contents as they will be once the current beat lands, so a
    // segment can be consumed on the same edge as its final word.
    always_comb begin
        w_next = r_shadow;
        if (i_wr_en) begin
            w_next[AXIS_W*int'(r_count) +: AXIS_W] = i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_count  <= '0;
        end else if (i_wr_en) begin
            r_shadow <= w_next;
            r_count  <= (r_count == c_last_idx) ? '0 : r_count + 1'b1;
        end
    end

    assign o_next  = w_next;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ndp_axis_unpacker.sv
// ============================================================================
// Module      : ndp_axis_unpacker
// Description : Deserializes the 32-bit NDP host stream into per-k operand steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ndp_axis_unpacker
    import ndp_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int ARR_HEIGHT = 4,
    parameter  int ARR_WIDTH  = 4,
    parameter  int SYS_HEIGHT = 1,
    parameter  int SYS_WIDTH  = 16,
    parameter  int K_DEPTH    = 21,
    localparam int A_BITS     = a_bits(WIDTH, SYS_HEIGHT, ARR_HEIGHT),
    localparam int B_BITS     = b_bits(WIDTH, SYS_WIDTH, ARR_WIDTH),
    localparam int A_WORDS    = words_of(A_BITS),
    localparam int B_WORDS    = words_of(B_BITS),
    localparam int K_W        = cnt_w(K_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [A_BITS-1:0] step_act,
    output logic [B_BITS-1:0] step_wgt,
    output logic [K_W-1:0]    step_k,
    output logic              step_last,
    input  logic              frame_release,
    output logic              busy,
    output logic              err_early_last,
    output logic              err_missing_last
);

    localparam int A_CW = cnt_w(A_WORDS);
    localparam int B_CW = cnt_w(B_WORDS);
    localparam logic [A_CW-1:0] c_a_last = A_CW'(A_WORDS - 1);
    localparam logic [B_CW-1:0] c_b_last = B_CW'(B_WORDS - 1);
    localparam logic [K_W-1:0]  c_k_last = K_W'(K_DEPTH - 1);

    state_t            r_state;
    logic [K_W-1:0]    r_k_cnt;
    logic              r_step_valid;
    logic [A_BITS-1:0] r_step_act;
    logic [B_BITS-1:0] r_step_wgt;
    logic [K_W-1:0]    r_step_k;
    logic              r_step_last;
    logic              r_rel_pend;
    logic              r_err_early;
    logic              r_err_missing;

    logic [A_BITS-1:0] w_a_next;
    logic [B_BITS-1:0] w_b_next;
    logic [A_CW-1:0]   w_a_cnt;
    logic [B_CW-1:0]   w_b_cnt;
    logic              w_completes;
    logic              w_frame_end;
    logic              w_tready;
    logic              w_beat;
    logic              w_early;
    logic              w_load;
    logic              w_handoff;
    logic              w_release;

    assign w_completes = (r_state == S_WGT) && (w_b_cnt == c_b_last);
    assign w_frame_end = w_completes && (r_k_cnt == c_k_last);
    // Only the step-completing beat has to wait for a pending step to drain.
    assign w_tready    = (r_state != S_HOLD) &&
                         !(w_completes && r_step_valid && !step_ready);
    assign w_beat      = s_axis_tvalid && w_tready;
    assign w_early     = w_beat && s_axis_tlast && !w_frame_end;
    assign w_load      = w_beat && w_completes && !w_early;
    assign w_handoff   = !r_step_valid || step_ready;
    assign w_release   = frame_release || r_rel_pend;

    ndp_word_packer #(.WORDS(A_WORDS)) u_pack_a (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clear   (w_early),
        .i_wr_en   (w_beat && (r_state == S_ACT)),
        .i_wr_data (s_axis_tdata),
        .o_next    (w_a_next),
        .o_count   (w_a_cnt)
    );

    ndp_word_packer #(.WORDS(B_WORDS)) u_pack_b (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clear   (w_early),
        .i_wr_en   (w_beat && (r_state == S_WGT)),
        .i_wr_data (s_axis_tdata),
        .o_next    (w_b_next),
        .o_count   (w_b_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_ACT;
            r_k_cnt       <= '0;
            r_step_valid  <= 1'b0;
            r_step_act    <= '0;
            r_step_wgt    <= '0;
            r_step_k      <= '0;
            r_step_last   <= 1'b0;
            r_rel_pend    <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            if (w_load) begin
                r_step_valid <= 1'b1;
                r_step_act   <= w_a_next;
                r_step_wgt   <= w_b_next;
                r_step_k     <= r_k_cnt;
                r_step_last  <= w_frame_end;
            end else if (step_ready) begin
                r_step_valid <= 1'b0;
            end

            if (w_early) begin
                r_err_early <= 1'b1;
            end
            if (w_load && w_frame_end && !s_axis_tlast) begin
                r_err_missing <= 1'b1;
            end

            case (r_state)
                S_ACT: begin
                    if (w_early) begin
                        r_k_cnt <= '0;
                    end else if (w_beat && (w_a_cnt == c_a_last)) begin
                        r_state <= S_WGT;
                    end
                end
                S_WGT: begin
                    if (w_early) begin
                        r_k_cnt <= '0;
                        r_state <= S_ACT;
                    end else if (w_load) begin
                        if (w_frame_end) begin
                            r_state    <= S_HOLD;
                            r_rel_pend <= frame_release;
                        end else begin
                            r_k_cnt <= r_k_cnt + 1'b1;
                            r_state <= S_ACT;
                        end
                    end
                end
                S_HOLD: begin
                    // A release seen while the final step is still pending is kept.
                    if (w_handoff && w_release) begin
                        r_state    <= S_ACT;
                        r_k_cnt    <= '0;
                        r_rel_pend <= 1'b0;
                    end else if (frame_release) begin
                        r_rel_pend <= 1'b1;
                    end
                end
                default: r_state <= S_ACT;
            endcase
        end
    end

    assign s_axis_tready    = w_tready;
    assign step_valid       = r_step_valid;
    assign step_act         = r_step_act;
    assign step_wgt         = r_step_wgt;
    assign step_k           = r_step_k;
    assign step_last        = r_step_last;
    assign busy             = (r_state != S_ACT) || (w_a_cnt != '0) ||
                              (r_k_cnt != '0) || r_step_valid;
    assign err_early_last   = r_err_early;
    assign err_missing_last = r_err_missing;

endmodule

`default_nettype wire
